// File: rtl/seq_mult_2bit_digit_pkg.sv
// Shared definitions for the digit-serial multiplier: digit width, FSM encoding,
// and index-width helper. Pure declarations, no timing or flow control.
package seq_mult_2bit_digit_pkg;

   localparam int DIGIT_W = 2;
   localparam int PP_W    = 2 * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A digit index needs at least one bit, even for a single-digit operand.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_mult_2bit_digit_pp.sv
// 2x2 unsigned combinational multiplier cell producing one 4-bit partial product.
// Zero latency, no flow control.
module multiplier (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] p
);

   logic a0b0, a1b0, a0b1, a1b1, c1;

   always_comb begin
      a0b0 = a[0] & b[0];
      a1b0 = a[1] & b[0];
      a0b1 = a[0] & b[1];
      a1b1 = a[1] & b[1];
      c1   = a1b0 & a0b1;
      p[0] = a0b0;
      p[1] = a1b0 ^ a0b1;
      p[2] = a1b1 ^ c1;
      p[3] = a1b1 & c1;
   end

endmodule

// File: rtl/seq_mult_2bit_digit.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier: one 2x2 digit pair per cycle, N*N+2 cycles
// from accepted start to done; start is ignored while busy or finishing (no queuing).
module seq_mult_2bit_digit
   import seq_mult_2bit_digit_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int N  = WIDTH / DIGIT_W;
   localparam int IW = idx_w(N);
   localparam int PW = 2 * WIDTH;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t            state, state_nx;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [PW-1:0]     acc, acc_nx, pp_shift;
   logic [IW-1:0]     i, j;
   logic [DIGIT_W-1:0] a_dig, b_dig;
   logic [PP_W-1:0]   pp;
   logic              last_pair;

   always_comb begin
      a_dig     = a_q[DIGIT_W*int'(i) +: DIGIT_W];
      b_dig     = b_q[DIGIT_W*int'(j) +: DIGIT_W];
      last_pair = (i == LAST) && (j == LAST);
   end

   multiplier u_pp (
      .a (a_dig),
      .b (b_dig),
      .p (pp)
   );

   // Partial product is zero-extended to full product width before being placed.
   always_comb begin
      pp_shift = PW'(pp) << (DIGIT_W * (int'(i) + int'(j)));
      acc_nx   = acc + pp_shift;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_pair) state_nx = ST_DONE;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         acc   <= '0;
         i     <= '0;
         j     <= '0;
         p     <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_q <= a;
                  b_q <= b;
                  acc <= '0;
                  i   <= '0;
                  j   <= '0;
               end
            end
            ST_RUN: begin
               acc <= acc_nx;
               // j is the inner index; indices return to zero after the final pair.
               if (last_pair) begin
                  i <= '0;
                  j <= '0;
               end else if (j == LAST) begin
                  j <= '0;
                  i <= i + 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            ST_DONE: begin
               p <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_2bit_digit.sv
// Bench for seq_mult_2bit_digit at WIDTH=4 and WIDTH=8: directed vectors plus an
// exhaustive 4-bit sweep, with expected products queued and checked on each done.
module tb_seq_mult_2bit_digit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start8;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic        busy4, done4, busy8, done8;
   logic [7:0]  p4;
   logic [15:0] p8;

   always #5 clk = ~clk;

   seq_mult_2bit_digit #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .p     (p4)
   );

   seq_mult_2bit_digit #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .p     (p8)
   );

   logic [7:0]  q4[$];
   logic [15:0] q8[$];
   int n_cmp = 0;
   int n_bad = 0;
   int dones4 = 0;
   int dones8 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: every done pops one expected product.
   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         dones4++;
         if (q4.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done4_unexpected: got done with p=%0d, expected no done", p4);
         end else begin
            chk("p4", 32'(p4), 32'(q4.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         dones8++;
         if (q8.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done8_unexpected: got done with p=%0d, expected no done", p8);
         end else begin
            chk("p8", 32'(p8), 32'(q8.pop_front()));
         end
      end
   end

   // One operation: start, accept edge, then wait for done checking latency and busy length.
   task automatic op(input bit w8, input int aa, input int bb, input int expp, input int prev_p);
      int  nn, nbusy, k;
      bit  got;
      nn = w8 ? 4 : 2;
      if (w8) begin
         a8 = 8'(aa); b8 = 8'(bb); start8 = 1'b1;
         q8.push_back(16'(expp));
      end else begin
         a4 = 4'(aa); b4 = 4'(bb); start4 = 1'b1;
         q4.push_back(8'(expp));
      end
      @(posedge clk);
      #1;
      start4 = 1'b0;
      start8 = 1'b0;
      nbusy = 0;
      got   = 1'b0;
      k     = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if ((w8 ? busy8 : busy4) === 1'b1) nbusy++;
         if (prev_p >= 0 && c == 3)
            chk("p_hold", w8 ? 32'(p8) : 32'(p4), 32'(prev_p));
         if ((w8 ? done8 : done4) === 1'b1) begin
            k   = c;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL op_timeout: got no done within 100 cycles, expected done for %0d*%0d", aa, bb);
      end else begin
         chk("latency", 32'(k), 32'(nn*nn + 2));
         chk("busy_cycles", 32'(nbusy), 32'(nn*nn));
      end
   endtask

   task automatic wait_done4(input string name, output int cyc);
      cyc = -1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (done4 === 1'b1) begin
            cyc = c;
            break;
         end
      end
      if (cyc < 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no done within 50 cycles, expected a done", name);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, cyc;
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy4", 32'(busy4), 0);
      chk("rst_done4", 32'(done4), 0);
      chk("rst_p4",    32'(p4),    0);
      chk("rst_busy8", 32'(busy8), 0);
      chk("rst_p8",    32'(p8),    0);

      // 1: basic product and timing
      op(1'b0, 3, 3, 9, -1);
      // 2: maximum operands, then zero result with p holding the previous value
      op(1'b0, 15, 15, 225, -1);
      op(1'b0, 0, 13, 0, 225);

      // 3: start held high across two operations
      a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
      q4.push_back(8'd63);
      q4.push_back(8'd30);
      @(posedge clk);
      #1 a4 = 4'd5; b4 = 4'd6;
      wait_done4("held_first_done", cyc);
      chk("held_first_latency", 32'(cyc), 6);
      chk("held_busy_at_done", 32'(busy4), 0);
      @(posedge clk);
      #1 start4 = 1'b0;
      @(negedge clk);
      chk("held_busy_after_done", 32'(busy4), 1);
      wait_done4("held_second_done", cyc);
      chk("held_second_latency", 32'(cyc), 5);

      // 4: start pulse and operand changes mid-run are ignored
      @(posedge clk);
      #1;
      d0 = dones4;
      a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
      q4.push_back(8'd42);
      @(posedge clk);
      #1 start4 = 1'b0;
      @(posedge clk);
      #1 start4 = 1'b1; a4 = 4'd2; b4 = 4'd2;
      @(posedge clk);
      #1 start4 = 1'b0; a4 = 4'd9; b4 = 4'd5;
      repeat (20) @(posedge clk);
      #1;
      chk("midrun_single_done", 32'(dones4), 32'(d0 + 1));

      // 5: reset mid-run abandons the operation
      a4 = 4'd11; b4 = 4'd13; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy4), 0);
      chk("midrst_done", 32'(done4), 0);
      chk("midrst_p",    32'(p4),    0);
      d0 = dones4;
      repeat (12) @(posedge clk);
      #1;
      chk("midrst_no_done", 32'(dones4), 32'(d0));
      op(1'b0, 11, 13, 143, -1);

      // rst and start together: reset wins
      @(posedge clk);
      #1 rst = 1'b1; start4 = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; start4 = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", 32'(busy4), 0);
      chk("rst_start_p",    32'(p4),    0);

      // 6: exhaustive 4-bit sweep, back-to-back
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            op(1'b0, x, y, x * y, -1);

      // WIDTH=8
      op(1'b1, 255, 255, 65025, -1);
      op(1'b1, 200, 123, 24600, 65025);
      op(1'b1, 0, 255, 0, -1);

      repeat (5) @(posedge clk);
      #1;
      chk("q4_drained", 32'(q4.size()), 0);
      chk("q8_drained", 32'(q8.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
